// File: rtl/output_layer_pkg.sv
// Shared constants for the output-layer accumulator: class count, widths
// and the FSM state encoding.
package output_layer_pkg;

  localparam int unsigned N_OUT   = 10;
  localparam int unsigned CLASS_W = 4;
  localparam int unsigned SEL_W   = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_ARGMAX = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/output_mac_lane.sv
// One multiply-accumulate lane: unsigned activation x signed weight, added
// into a signed accumulator. Optional macro ACC_SAT_EN selects saturating
// adds; without it the accumulator wraps in two's complement.
module output_mac_lane #(
  parameter int unsigned ACT_WIDTH = 8,
  parameter int unsigned W_WIDTH   = 8,
  parameter int unsigned ACC_WIDTH = 24
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        en,
  input  logic        [ACT_WIDTH-1:0] act,
  input  logic signed [W_WIDTH-1:0]   weight,
  output logic signed [ACC_WIDTH-1:0] acc
);

  localparam int unsigned PROD_W = ACT_WIDTH + W_WIDTH;

  logic signed [PROD_W-1:0]    prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] next_acc;

  // Activation gets a zero sign bit so the multiply stays signed.
  assign prod     = $signed({1'b0, act}) * weight;
  assign prod_ext = ACC_WIDTH'(prod);

`ifdef ACC_SAT_EN
  logic [ACC_WIDTH:0] sum_full;

  // Saturating add: one guard bit detects overflow, clamp to the range ends.
  always_comb begin
    sum_full = {acc[ACC_WIDTH-1], acc} + {prod_ext[ACC_WIDTH-1], prod_ext};
    if (sum_full[ACC_WIDTH] != sum_full[ACC_WIDTH-1]) begin
      next_acc = sum_full[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                     : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      next_acc = sum_full[ACC_WIDTH-1:0];
    end
  end
`else
  assign next_acc = acc + prod_ext;
`endif

  // Accumulator register: reset and clear dominate, otherwise add on enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= next_acc;
    end
  end

endmodule

// File: rtl/output_layer_accumulator.sv
// Output-layer compute stage: walks N_HIDDEN weight rows, accumulates ten
// class scores from the activation stream, then scans them for the argmax.
// Optional macro ACC_SAT_EN (in output_mac_lane) makes the lanes saturate.
module output_layer_accumulator
  import output_layer_pkg::*;
#(
  parameter int unsigned N_HIDDEN  = 30,
  parameter int unsigned ACT_WIDTH = 8,
  parameter int unsigned W_WIDTH   = 8,
  parameter int unsigned ACC_WIDTH = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      act_valid,
  input  logic        [ACT_WIDTH-1:0] act_data,
  output logic                      act_ready,
  output logic        [SEL_W-1:0]   weight_sel,
  input  logic signed [W_WIDTH-1:0] w0,
  input  logic signed [W_WIDTH-1:0] w1,
  input  logic signed [W_WIDTH-1:0] w2,
  input  logic signed [W_WIDTH-1:0] w3,
  input  logic signed [W_WIDTH-1:0] w4,
  input  logic signed [W_WIDTH-1:0] w5,
  input  logic signed [W_WIDTH-1:0] w6,
  input  logic signed [W_WIDTH-1:0] w7,
  input  logic signed [W_WIDTH-1:0] w8,
  input  logic signed [W_WIDTH-1:0] w9,
  output logic                      busy,
  output logic                      done,
  output logic        [CLASS_W-1:0] class_idx
);

  localparam int unsigned ROW_W = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1;

  logic [1:0]                  state;
  logic [ROW_W-1:0]            row;
  logic [CLASS_W-1:0]          scan_idx;
  logic [CLASS_W-1:0]          best_idx;
  logic signed [ACC_WIDTH-1:0] best_val;
  logic signed [ACC_WIDTH-1:0] cand;
  logic [CLASS_W-1:0]          pick_idx;
  logic                        take;
  logic                        beat;
  logic                        clear;

  logic signed [W_WIDTH-1:0]   weights [N_OUT];
  logic signed [ACC_WIDTH-1:0] acc     [N_OUT];

  assign weights[0] = w0;
  assign weights[1] = w1;
  assign weights[2] = w2;
  assign weights[3] = w3;
  assign weights[4] = w4;
  assign weights[5] = w5;
  assign weights[6] = w6;
  assign weights[7] = w7;
  assign weights[8] = w8;
  assign weights[9] = w9;

  assign act_ready  = (state == ST_ACCUM);
  assign busy       = (state == ST_ACCUM) || (state == ST_ARGMAX);
  assign done       = (state == ST_DONE);
  assign weight_sel = SEL_W'(row);
  assign beat       = act_valid && (state == ST_ACCUM);
  assign clear      = start && (state == ST_IDLE);

  for (genvar k = 0; k < N_OUT; k++) begin : gen_lane
    output_mac_lane #(
      .ACT_WIDTH (ACT_WIDTH),
      .W_WIDTH   (W_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (clear),
      .en     (beat),
      .act    (act_data),
      .weight (weights[k]),
      .acc    (acc[k])
    );
  end

  // Argmax candidate: lane under scan, and whether it beats the running best
  // (first lane always taken; strict '>' keeps the lowest index on ties).
  always_comb begin
    cand = '0;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      if (scan_idx == CLASS_W'(k)) cand = acc[k];
    end
    take     = (scan_idx == '0) || (cand > best_val);
    pick_idx = take ? scan_idx : best_idx;
  end

  // Control FSM with row counter and sequential argmax scan.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      row       <= '0;
      scan_idx  <= '0;
      best_idx  <= '0;
      best_val  <= '0;
      class_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_ACCUM;
            row   <= '0;
          end
        end
        ST_ACCUM: begin
          if (act_valid) begin
            if (row == ROW_W'(N_HIDDEN - 1)) begin
              row      <= '0;
              scan_idx <= '0;
              state    <= ST_ARGMAX;
            end else begin
              row <= row + ROW_W'(1);
            end
          end
        end
        ST_ARGMAX: begin
          if (take) begin
            best_val <= cand;
            best_idx <= scan_idx;
          end
          if (scan_idx == CLASS_W'(N_OUT - 1)) begin
            class_idx <= pick_idx;
            state     <= ST_DONE;
          end else begin
            scan_idx <= scan_idx + CLASS_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_layer_accumulator.sv
// Bench for output_layer_accumulator: behavioural weight-memory stub, a
// reference model for the class scores, and a scoreboard queue of expected
// results popped when done is seen. A second instance uses ACC_WIDTH=16.
`timescale 1ns/1ps
module tb_output_layer_accumulator;

  localparam int unsigned N_HIDDEN = 30;

  typedef struct {
    int cls;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, act_valid, use_b;
  logic [7:0] act_data;
  int         mode;

  logic        ready_a, busy_a, done_a, ready_b, busy_b, done_b;
  logic [31:0] sel_a, sel_b;
  logic [3:0]  cls_a, cls_b;
  logic signed [7:0] wa [10];
  logic signed [7:0] wb [10];

  logic        o_ready, o_busy, o_done;
  logic [31:0] o_sel;
  logic [3:0]  o_cls;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  output_layer_accumulator #(.N_HIDDEN(N_HIDDEN), .ACT_WIDTH(8), .W_WIDTH(8), .ACC_WIDTH(24)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start && !use_b), .act_valid(act_valid), .act_data(act_data),
    .act_ready(ready_a), .weight_sel(sel_a),
    .w0(wa[0]), .w1(wa[1]), .w2(wa[2]), .w3(wa[3]), .w4(wa[4]),
    .w5(wa[5]), .w6(wa[6]), .w7(wa[7]), .w8(wa[8]), .w9(wa[9]),
    .busy(busy_a), .done(done_a), .class_idx(cls_a));

  output_layer_accumulator #(.N_HIDDEN(N_HIDDEN), .ACT_WIDTH(8), .W_WIDTH(8), .ACC_WIDTH(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start && use_b), .act_valid(act_valid), .act_data(act_data),
    .act_ready(ready_b), .weight_sel(sel_b),
    .w0(wb[0]), .w1(wb[1]), .w2(wb[2]), .w3(wb[3]), .w4(wb[4]),
    .w5(wb[5]), .w6(wb[6]), .w7(wb[7]), .w8(wb[8]), .w9(wb[9]),
    .busy(busy_b), .done(done_b), .class_idx(cls_b));

  function automatic logic signed [7:0] wfun(input int m, input int r, input int k);
    case (m)
      0:       return 8'(k);
      1:       return 8'sd5;
      2:       return (k == 3) ? 8'sd1 : -8'sd1;
      3:       return (k == 0) ? 8'sd127 : ((k == 1) ? 8'sd1 : 8'sd0);
      default: return 8'((r * 7 + k * 13 + 3) % 256);
    endcase
  endfunction

  function automatic int afun(input int m, input int r);
    case (m)
      0:       return 1;
      1:       return 7;
      2:       return 200;
      3:       return 255;
      default: return (r * 37 + 11) % 256;
    endcase
  endfunction

  // Reference: accumulate at the given width (wrap or saturate), then argmax.
  function automatic int model_class(input int m, input int width);
    longint acc [10];
    longint maxv, minv, p, s;
    int best;
    maxv = (longint'(1) <<< (width - 1)) - 1;
    minv = -maxv - 1;
    for (int k = 0; k < 10; k++) acc[k] = 0;
    for (int r = 0; r < int'(N_HIDDEN); r++) begin
      for (int k = 0; k < 10; k++) begin
        p = longint'(afun(m, r)) * longint'(wfun(m, r, k));
        s = acc[k] + p;
`ifdef ACC_SAT_EN
        if (s > maxv) s = maxv;
        if (s < minv) s = minv;
`else
        s = s & ((longint'(1) <<< width) - 1);
        if (s > maxv) s = s - (longint'(1) <<< width);
`endif
        acc[k] = s;
      end
    end
    best = 0;
    for (int k = 1; k < 10; k++) if (acc[k] > acc[best]) best = k;
    return best;
  endfunction

  // Behavioural weight memory: combinational read of the selected row.
  always_comb begin
    for (int k = 0; k < 10; k++) begin
      wa[k] = wfun(mode, int'(sel_a), k);
      wb[k] = wfun(mode, int'(sel_b), k);
    end
  end

  // Observation mux onto whichever instance is under test.
  always_comb begin
    o_ready = use_b ? ready_b : ready_a;
    o_busy  = use_b ? busy_b  : busy_a;
    o_done  = use_b ? done_b  : done_a;
    o_sel   = use_b ? sel_b   : sel_a;
    o_cls   = use_b ? cls_b   : cls_a;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".done"},       64'(o_done),  0);
    chk({tag, ".busy"},       64'(o_busy),  0);
    chk({tag, ".act_ready"},  64'(o_ready), 0);
    chk({tag, ".weight_sel"}, 64'(o_sel),   0);
  endtask

  // One inference: push expectation, drive start and beats, pop on done.
  task automatic run(input string tag, input int m, input bit on_b, input bit toggle,
                     input bit poke, input int exp_cyc);
    exp_t e;
    int   row;
    bit   got;
    mode  = m;
    use_b = on_b;
    e.cls = model_class(m, on_b ? 16 : 24);
    e.cyc = exp_cyc;
    sb.push_back(e);
    row = 0;
    got = 1'b0;
    @(negedge clk);
    start     = 1'b1;
    act_valid = 1'b0;
    for (int c = 1; c <= 200 && !got; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (o_done) begin
        e = sb.pop_front();
        chk({tag, ".class"},   64'(o_cls), 64'(e.cls));
        chk({tag, ".latency"}, 64'(c),     64'(e.cyc));
        chk({tag, ".beats"},   64'(row),   64'(N_HIDDEN));
        got = 1'b1;
      end else begin
        if (o_ready) chk({tag, ".weight_sel"}, o_sel, 64'(row));
        if (c <= int'(N_HIDDEN)) chk({tag, ".busy"}, 64'(o_busy), 1);
        act_valid = toggle ? (c % 2 == 0) : 1'b1;
        act_data  = o_ready ? 8'(afun(m, row)) : 8'hFF;
        if (act_valid && o_ready) row++;
        start = poke && o_busy && (c % 5 == 0);
      end
    end
    chk({tag, ".done_seen"}, 64'(got), 1);
    if (!got && sb.size() > 0) void'(sb.pop_front());
    act_valid = 1'b0;
    start     = 1'b0;
    @(negedge clk);
    check_idle({tag, ".after"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    act_valid = 1'b0;
    act_data  = '0;
    use_b     = 1'b0;
    mode      = 0;

    // Reset held two cycles.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_idle("reset_a");
    chk("reset_a.class_idx", 64'(cls_a), 0);
    use_b = 1'b1;
    check_idle("reset_b");
    chk("reset_b.class_idx", 64'(cls_b), 0);
    use_b = 1'b0;

    run("ramp",   0, 1'b0, 1'b0, 1'b0, int'(N_HIDDEN) + 11);
    run("tie",    1, 1'b0, 1'b0, 1'b0, int'(N_HIDDEN) + 11);
    run("toggle", 2, 1'b0, 1'b1, 1'b1, 71);
    run("w16",    3, 1'b1, 1'b0, 1'b0, int'(N_HIDDEN) + 11);
    run("w24",    3, 1'b0, 1'b0, 1'b0, int'(N_HIDDEN) + 11);
    run("mix24",  4, 1'b0, 1'b0, 1'b0, int'(N_HIDDEN) + 11);
    run("mix16",  4, 1'b1, 1'b0, 1'b0, int'(N_HIDDEN) + 11);

    // Abort after 10 beats; everything must return to reset values.
    mode  = 0;
    use_b = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      act_valid = 1'b1;
      act_data  = 8'd1;
      @(negedge clk);
    end
    rst_n     = 1'b0;
    act_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("abort");
    chk("abort.class_idx", 64'(cls_a), 0);

    run("rerun", 0, 1'b0, 1'b0, 1'b0, int'(N_HIDDEN) + 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
